cb_sequencer: RTL and testbench
===============================

CB_SEQUENCER -- requirements
Module: cb_sequencer

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 SHALL expose: i_Clk  input  1  rising-edge clock.
REQ-003 SHALL expose: i_Reset  input  1  synchronous active-high reset.
REQ-004 SHALL expose: i_CB_Prefix  input  1  one-cycle pulse; main decoder fetched 0xCB.
REQ-005 SHALL expose: i_Opcode  input  8  second opcode byte.
REQ-006 SHALL expose: i_Opcode_Valid  input  1  i_Opcode valid this cycle.
REQ-007 SHALL expose: i_Stall  input  1  memory wait; freezes sequencing.
REQ-008 SHALL expose: i_Disable_CB  input  1  end-of-instruction request from CB microcode.
REQ-009 SHALL expose: o_Active  output  1  CB microcode enable.
REQ-010 SHALL expose: o_Cycle_Step  output  4  one-hot T-state within the M-cycle.
REQ-011 SHALL expose: o_Cycle_Count  output  8  one-hot M-cycle index.
REQ-012 SHALL expose: o_Z  output  8  latched CB opcode.
REQ-013 SHALL expose: o_Busy  output  1  high in any state other than IDLE.
REQ-014 SHALL expose: o_Done  output  1  one-cycle pulse on normal completion.
REQ-015 SHALL expose: o_Error  output  1  one-cycle pulse on watchdog abort (tied 0 without macro).

Function
REQ-016 SHALL implement states IDLE, WAIT_OP, EXEC.
REQ-017 IDLE: on i_CB_Prefix -> WAIT_OP next cycle; other inputs ignored.
REQ-018 WAIT_OP: on i_Opcode_Valid, SHALL latch o_Z <= i_Opcode and -> EXEC with o_Cycle_Step=4'b0001, o_Cycle_Count=8'h01.
REQ-019 o_Active SHALL be 1 exactly when state is EXEC.
REQ-020 EXEC, i_Stall=0: o_Cycle_Step SHALL rotate 0001->0010->0100->1000->0001, one position per clock.
REQ-021 On the 1000->0001 rotation, o_Cycle_Count SHALL shift left one bit (8'h01->8'h02->...).
REQ-022 EXEC, i_Stall=1: o_Cycle_Step and o_Cycle_Count SHALL hold; i_Disable_CB SHALL be ignored.
REQ-023 EXEC, i_Stall=0, i_Disable_CB=1 with o_Cycle_Step=4'b1000: -> IDLE next cycle; o_Done=1 that cycle.
REQ-024 i_Disable_CB SHALL be ignored when o_Cycle_Step is not 4'b1000.
REQ-025 In IDLE and WAIT_OP, o_Cycle_Step=4'b0000 and o_Cycle_Count=8'h00.
REQ-026 o_Z SHALL hold its last value in IDLE until the next opcode latch.
REQ-027 i_CB_Prefix in WAIT_OP or EXEC SHALL be ignored (no nesting).
REQ-028 Expected length: o_Z[6]=0 -> 1 M-cycle (4 clocks unstalled); o_Z[6]=1 -> 3 M-cycles (12 clocks unstalled).
REQ-029 o_Done and o_Error SHALL never assert in the same cycle.

Reset
REQ-030 i_Reset SHALL force state IDLE, o_Active=0, o_Cycle_Step=4'b0000, o_Cycle_Count=8'h00, o_Z=8'h00, o_Busy=0, o_Done=0, o_Error=0 on the next edge.
REQ-031 Reset mid-EXEC SHALL abort without o_Done or o_Error; reset has priority over all inputs.

Configuration
REQ-032 Macro CB_SEQ_WATCHDOG_EN defined: in EXEC with o_Cycle_Count=8'h08, o_Cycle_Step=4'b1000, i_Stall=0, i_Disable_CB=0 -> IDLE next cycle with o_Error=1.
REQ-033 Macro CB_SEQ_WATCHDOG_EN undefined: o_Cycle_Count SHALL wrap 8'h80->8'h01, EXEC persists until i_Disable_CB; o_Error constant 0.

Verification
REQ-034 Reset, pulse i_CB_Prefix, i_Opcode=8'h37 valid next cycle, i_Disable_CB at count 8'h01 step 1000 -> 4 active clocks, o_Done pulse, back to IDLE.
REQ-035 i_Opcode=8'h46, i_Disable_CB at count 8'h04 step 1000 -> count sequence 01,02,04, 12 active clocks, o_Done once.
REQ-036 Opcode 8'h46, i_Stall high 3 clocks at count 8'h02 step 0100 -> step/count frozen 3 clocks, total 15 active clocks.
REQ-037 i_Disable_CB held high from EXEC entry -> exit only on first step 1000; second i_CB_Prefix during EXEC -> no effect.
REQ-038 i_Reset asserted at count 8'h02 step 0010 -> all outputs at reset values next cycle, no o_Done.
REQ-039 Watchdog build, i_Disable_CB never asserted -> o_Error pulse after 16 clocks of EXEC; non-watchdog build -> count wraps 8'h80->8'h01.

Source files
------------

// File: rtl/cb_sequencer.sv
// CB-prefix micro-sequencer: latches the second opcode byte and steps one-hot T-states/M-cycles until
// the CB microcode requests end of instruction. Optional watchdog abort enabled by `define CB_SEQ_WATCHDOG_EN.
module cb_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_CB_Prefix,
  input  logic [7:0] i_Opcode,
  input  logic       i_Opcode_Valid,
  input  logic       i_Stall,
  input  logic       i_Disable_CB,
  output logic       o_Active,
  output logic [3:0] o_Cycle_Step,
  output logic [7:0] o_Cycle_Count,
  output logic [7:0] o_Z,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_OP = 2'd1,
    EXEC    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] step;
  logic [7:0] count;
  logic [7:0] z;
  logic       done;
  logic       error;

  logic       advance;
  logic       finish;
  logic       wd_hit;
  logic       load_op;

  // Sequencing only moves in EXEC while memory is not holding us off.
  assign advance = (state == EXEC) && !i_Stall;
  assign finish  = advance && step[3] && i_Disable_CB;
  assign load_op = (state == WAIT_OP) && i_Opcode_Valid;

`ifdef CB_SEQ_WATCHDOG_EN
  // Longest legal CB instruction is well under four M-cycles; reaching the end of the fourth means stuck microcode.
  assign wd_hit = advance && step[3] && !i_Disable_CB && (count == 8'h08);
`else
  assign wd_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_CB_Prefix) state_next = WAIT_OP;
      WAIT_OP: if (i_Opcode_Valid) state_next = EXEC;
      EXEC:    if (finish || wd_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_Active = (state == EXEC);
    o_Busy   = (state != IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      step  <= 4'b0000;
      count <= 8'h00;
    end else if (load_op) begin
      step  <= 4'b0001;
      count <= 8'h01;
    end else if (finish || wd_hit) begin
      step  <= 4'b0000;
      count <= 8'h00;
    end else if (advance) begin
      step <= {step[2:0], step[3]};
      // Rotating (rather than shifting) lets a watchdog-less build wrap 8'h80 back to 8'h01.
      if (step[3]) count <= {count[6:0], count[7]};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset)      z <= 8'h00;
    else if (load_op) z <= i_Opcode;
  end

  // finish and wd_hit are mutually exclusive by construction (wd_hit requires !i_Disable_CB).
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= finish;
      error <= wd_hit;
    end
  end

  assign o_Cycle_Step  = step;
  assign o_Cycle_Count = count;
  assign o_Z           = z;
  assign o_Done        = done;
  assign o_Error       = error;

  a_done_error_excl : assert property (@(posedge i_Clk) disable iff (i_Reset)
    !(o_Done && o_Error));
  a_exec_onehot : assert property (@(posedge i_Clk) disable iff (i_Reset)
    o_Active |-> ($onehot(o_Cycle_Step) && $onehot(o_Cycle_Count)));
  a_idle_zero : assert property (@(posedge i_Clk) disable iff (i_Reset)
    !o_Active |-> (o_Cycle_Step == 4'b0000 && o_Cycle_Count == 8'h00));

endmodule

// File: tb/tb_cb_sequencer.sv
// Self-checking bench for cb_sequencer: directed scenarios plus random traffic, every cycle compared
// against a T-state/M-cycle index model.
module tb_cb_sequencer;

  logic       i_Clk;
  logic       i_Reset;
  logic       i_CB_Prefix;
  logic [7:0] i_Opcode;
  logic       i_Opcode_Valid;
  logic       i_Stall;
  logic       i_Disable_CB;
  logic       o_Active;
  logic [3:0] o_Cycle_Step;
  logic [7:0] o_Cycle_Count;
  logic [7:0] o_Z;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Error;

  cb_sequencer dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_CB_Prefix    (i_CB_Prefix),
    .i_Opcode       (i_Opcode),
    .i_Opcode_Valid (i_Opcode_Valid),
    .i_Stall        (i_Stall),
    .i_Disable_CB   (i_Disable_CB),
    .o_Active       (o_Active),
    .o_Cycle_Step   (o_Cycle_Step),
    .o_Cycle_Count  (o_Cycle_Count),
    .o_Z            (o_Z),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Error        (o_Error)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: phase 0=idle, 1=waiting for opcode, 2=executing; t = T-state index, m = M-cycle index.
  int         m_phase = 0;
  int         m_t     = 0;
  int         m_m     = 0;
  logic [7:0] m_z     = 8'h00;
  bit         m_done  = 1'b0;
  bit         m_err   = 1'b0;

`ifdef CB_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  int         active_cnt = 0;
  int         done_cnt   = 0;
  int         err_cnt    = 0;
  logic [7:0] prev_count = 8'h00;
  bit         seen_wrap  = 1'b0;

  task automatic model_step(input bit rst, pre, input logic [7:0] op, input bit vld, stl, dis);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_phase = 0; m_t = 0; m_m = 0; m_z = 8'h00;
    end else begin
      case (m_phase)
        0: if (pre) m_phase = 1;
        1: if (vld) begin m_z = op; m_phase = 2; m_t = 0; m_m = 0; end
        default: if (!stl) begin
          if (m_t == 3 && dis) begin
            m_phase = 0; m_done = 1'b1;
          end else if (WD && m_t == 3 && m_m == 3) begin
            m_phase = 0; m_err = 1'b1;
          end else if (m_t == 3) begin
            m_t = 0; m_m = (m_m + 1) % 8;
          end else begin
            m_t = m_t + 1;
          end
        end
      endcase
    end
  endtask

  task automatic cycle(input bit rst, pre, input logic [7:0] op, input bit vld, stl, dis);
    logic [3:0] exp_step;
    logic [7:0] exp_count;
    @(negedge i_Clk);
    i_Reset = rst; i_CB_Prefix = pre; i_Opcode = op;
    i_Opcode_Valid = vld; i_Stall = stl; i_Disable_CB = dis;
    @(posedge i_Clk);
    model_step(rst, pre, op, vld, stl, dis);
    #1;
    exp_step  = (m_phase == 2) ? (4'b0001 << m_t) : 4'b0000;
    exp_count = (m_phase == 2) ? (8'h01 << m_m) : 8'h00;
    check("active", o_Active, (m_phase == 2));
    check("busy", o_Busy, (m_phase != 0));
    check("step", o_Cycle_Step, exp_step);
    check("count", o_Cycle_Count, exp_count);
    check("z", o_Z, m_z);
    check("done", o_Done, m_done);
    check("error", o_Error, m_err);
    if (o_Active) active_cnt++;
    if (o_Done) done_cnt++;
    if (o_Error) err_cnt++;
    if (prev_count == 8'h80 && o_Cycle_Count == 8'h01) seen_wrap = 1'b1;
    prev_count = o_Cycle_Count;
  endtask

  task automatic clear_counts();
    active_cnt = 0; done_cnt = 0; err_cnt = 0; seen_wrap = 1'b0;
  endtask

  // One CB instruction: dis_m = M-cycle index at which to request exit (-1 never), dis_hold keeps
  // i_Disable_CB high throughout, stall_n stalls at count 02 step 0100. A stray prefix is sent mid-EXEC.
  task automatic run_cmd(input logic [7:0] op, input int dis_m, input bit dis_hold,
                         input int stall_n, input int n_max);
    int  stall_left = 0;
    bit  stalled = 1'b0;
    bit  stl, dis;
    clear_counts();
    cycle(0, 1, 8'h00, 0, 0, 0);
    cycle(0, 0, op, 1, 0, dis_hold);
    for (int i = 0; i < n_max; i++) begin
      if (m_phase == 0) break;
      if (!stalled && stall_n > 0 && m_m == 1 && m_t == 2) begin
        stalled = 1'b1; stall_left = stall_n;
      end
      stl = (stall_left > 0);
      if (stl) stall_left--;
      dis = dis_hold || (m_t == 3 && m_m == dis_m);
      cycle(0, (i == 2), $urandom_range(255), $urandom_range(1), stl, dis);
    end
  endtask

  initial begin
    i_Reset = 1'b1; i_CB_Prefix = 1'b0; i_Opcode = 8'h00;
    i_Opcode_Valid = 1'b0; i_Stall = 1'b0; i_Disable_CB = 1'b0;

    cycle(1, 0, 8'h00, 0, 0, 0);
    cycle(1, 1, 8'hFF, 1, 1, 1);
    cycle(0, 0, 8'hAA, 1, 0, 1);
    check("idle_ignores_opcode_z", o_Z, 8'h00);

    // Short instruction: one M-cycle.
    run_cmd(8'h37, 0, 1'b0, 0, 40);
    check("short_active_clocks", active_cnt, 4);
    check("short_done_count", done_cnt, 1);
    check("short_z", o_Z, 8'h37);
    cycle(0, 0, 8'h00, 0, 0, 0);
    check("short_back_idle", o_Busy, 0);

    // Long instruction: three M-cycles.
    run_cmd(8'h46, 2, 1'b0, 0, 40);
    check("long_active_clocks", active_cnt, 12);
    check("long_done_count", done_cnt, 1);

    // Long instruction with a 3-clock stall at count 02 step 0100.
    run_cmd(8'h46, 2, 1'b0, 3, 40);
    check("stall_active_clocks", active_cnt, 15);
    check("stall_done_count", done_cnt, 1);

    // Disable held from entry: exit at the first step 1000 only.
    run_cmd(8'hC5, -1, 1'b1, 0, 40);
    check("hold_active_clocks", active_cnt, 4);
    check("hold_done_count", done_cnt, 1);
    check("hold_z", o_Z, 8'hC5);

    // Reset at count 02 step 0010.
    clear_counts();
    cycle(0, 1, 8'h00, 0, 0, 0);
    cycle(0, 0, 8'h46, 1, 0, 0);
    for (int i = 0; i < 20 && !(m_m == 1 && m_t == 1); i++) cycle(0, 0, 8'h00, 0, 0, 0);
    check("pre_reset_count", o_Cycle_Count, 8'h02);
    check("pre_reset_step", o_Cycle_Step, 4'b0010);
    cycle(1, 0, 8'h00, 0, 0, 1);
    check("reset_mid_z", o_Z, 8'h00);
    check("reset_mid_busy", o_Busy, 0);
    check("reset_mid_no_done", done_cnt, 0);
    cycle(0, 0, 8'h00, 0, 0, 0);
    check("reset_mid_no_done_after", o_Done, 0);

    // Never-ending instruction: watchdog abort or count wrap.
    run_cmd(8'h46, -1, 1'b0, 0, 40);
    if (WD) begin
      check("wd_active_clocks", active_cnt, 16);
      check("wd_error_count", err_cnt, 1);
      check("wd_done_count", done_cnt, 0);
    end else begin
      check("wrap_seen", seen_wrap, 1);
      check("wrap_error_count", err_cnt, 0);
      check("wrap_still_active", o_Active, 1);
      cycle(1, 0, 8'h00, 0, 0, 0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(9) == 0), $urandom_range(255),
            ($urandom_range(2) == 0), ($urandom_range(4) == 0), ($urandom_range(2) == 0));
      check("done_error_excl", (o_Done && o_Error), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
